// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, key map and helpers for the keypad scanner
//
// Contents:
//   state_t      scanner FSM states
//   KEY_MAP      hex code per key, indexed [row][col]
//   col_onehot_n active-low one-hot column drive for a column index
//   lowest_row   index of the lowest pressed (low) row
//   sat_inc      24-bit saturating increment
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN        = 2'd0,
    DEB_PRESS   = 2'd1,
    HELD        = 2'd2,
    DEB_RELEASE = 2'd3
  } state_t;

  // Packed as {row3, row2, row1, row0}, each row as {col3, col2, col1, col0},
  // so KEY_MAP[row][col] reads the physical legend directly.
  localparam logic [3:0][3:0][3:0] KEY_MAP = {
    {4'hD, 4'hF, 4'h0, 4'hE},
    {4'hC, 4'h9, 4'h8, 4'h7},
    {4'hB, 4'h6, 4'h5, 4'h4},
    {4'hA, 4'h3, 4'h2, 4'h1}
  };

  function automatic logic [3:0] col_onehot_n(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  // Rows are active-low; when several are low the lowest index wins.
  function automatic logic [1:0] lowest_row(input logic [3:0] rows_n);
    if (!rows_n[0])      return 2'd0;
    else if (!rows_n[1]) return 2'd1;
    else if (!rows_n[2]) return 2'd2;
    else                 return 2'd3;
  endfunction

  function automatic logic [23:0] sat_inc(input logic [23:0] v);
    return (v == 24'hFF_FFFF) ? v : v + 24'd1;
  endfunction

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - parameterizable-width two-flop synchronizer
//
// Ports:
//   clk    system clock
//   reset  synchronous, active-low; loads RESET_VAL into both stages
//   d      asynchronous input bus
//   q      synchronized output bus (two clk cycles of latency)
module sync2 #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// rtl/keypad_scan_ctrl.sv - 4x4 matrix keypad scanner with debounce and lockout
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-low reset
//   row_n[3:0] raw keypad rows, active-low, asynchronous to clk
//   col_n[3:0] column drive, one-hot active-low
//   key_valid  one-cycle pulse when a debounced key is accepted
//   key_code   hex code of the last accepted key, held between pulses
//   key_held   high while the accepted key remains pressed
//
// Build option: define KEYPAD_REPEAT_EN to re-pulse key_valid every
// REPEAT_CYCLES cycles while a key is held.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter logic [23:0] SCAN_DIV        = 24'd10000,
  parameter logic [23:0] DEBOUNCE_CYCLES = 24'd150000,
  parameter logic [23:0] REPEAT_CYCLES   = 24'd3000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held
);

  logic [3:0]  rs;
  state_t      state;
  logic [1:0]  col_idx;
  logic [1:0]  lat_row;
  logic [1:0]  lat_col;
  logic [23:0] dwell_cnt;
  logic [23:0] deb_cnt;
  logic        row_up;
  logic        dwell_done;
  logic        deb_done;

  sync2 #(
    .WIDTH     (4),
    .RESET_VAL (4'b1111)
  ) u_row_sync (
    .clk   (clk),
    .reset (reset),
    .d     (row_n),
    .q     (rs)
  );

  // Level of the row that started the current press; 1 means released.
  assign row_up     = rs[lat_row];
  assign dwell_done = (dwell_cnt == SCAN_DIV - 24'd1);
  // Widened compare so DEBOUNCE_CYCLES of 0 or 1 still terminates.
  assign deb_done   = (({1'b0, deb_cnt} + 25'd1) >= {1'b0, DEBOUNCE_CYCLES});

`ifdef KEYPAD_REPEAT_EN
  logic [23:0] rep_cnt;
  logic        rep_done;
  assign rep_done = (({1'b0, rep_cnt} + 25'd1) >= {1'b0, REPEAT_CYCLES});
`else
  // Parameter stays on the interface so both builds share one instantiation.
  logic [23:0] repeat_unused;
  assign repeat_unused = REPEAT_CYCLES;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= SCAN;
      col_idx   <= 2'd0;
      col_n     <= 4'b1110;
      lat_row   <= 2'd0;
      lat_col   <= 2'd0;
      dwell_cnt <= 24'd0;
      deb_cnt   <= 24'd0;
      key_valid <= 1'b0;
      key_code  <= 4'h0;
      key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt   <= 24'd0;
`endif
    end else begin
      key_valid <= 1'b0;
      case (state)
        SCAN: begin
          if (dwell_done) begin
            dwell_cnt <= 24'd0;
            if (rs != 4'b1111) begin
              // Column stays frozen from here until the key is released.
              lat_col <= col_idx;
              lat_row <= lowest_row(rs);
              deb_cnt <= 24'd0;
              state   <= DEB_PRESS;
            end else begin
              col_idx <= col_idx + 2'd1;
              col_n   <= col_onehot_n(col_idx + 2'd1);
            end
          end else begin
            dwell_cnt <= sat_inc(dwell_cnt);
          end
        end

        DEB_PRESS: begin
          if (row_up) begin
            // Bounce: drop it and move on rather than rescanning this column.
            deb_cnt   <= 24'd0;
            dwell_cnt <= 24'd0;
            col_idx   <= col_idx + 2'd1;
            col_n     <= col_onehot_n(col_idx + 2'd1);
            state     <= SCAN;
          end else if (deb_done) begin
            deb_cnt   <= 24'd0;
            key_code  <= KEY_MAP[lat_row][lat_col];
            key_valid <= 1'b1;
            key_held  <= 1'b1;
            state     <= HELD;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt   <= 24'd0;
`endif
          end else begin
            deb_cnt <= sat_inc(deb_cnt);
          end
        end

        HELD: begin
`ifdef KEYPAD_REPEAT_EN
          // Guard keeps pulses apart even with REPEAT_CYCLES of 1.
          if (rep_done) begin
            rep_cnt <= 24'd0;
            if (!key_valid) key_valid <= 1'b1;
          end else begin
            rep_cnt <= sat_inc(rep_cnt);
          end
`endif
          if (row_up) begin
            deb_cnt <= 24'd0;
            state   <= DEB_RELEASE;
          end
        end

        DEB_RELEASE: begin
          // Repeat counter is left untouched here so a release bounce
          // does not restart the repeat period.
          if (!row_up) begin
            deb_cnt <= 24'd0;
            state   <= HELD;
          end else if (deb_done) begin
            deb_cnt   <= 24'd0;
            dwell_cnt <= 24'd0;
            key_held  <= 1'b0;
            col_idx   <= col_idx + 2'd1;
            col_n     <= col_onehot_n(col_idx + 2'd1);
            state     <= SCAN;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt   <= 24'd0;
`endif
          end else begin
            deb_cnt <= sat_inc(deb_cnt);
          end
        end

        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
- Sequences the 4x4 matrix keypad: drives one column at a time, samples the rows, debounces the press, and locks the key until it is released.
- Emits exactly one `key_valid` pulse with a hex key code per debounced press.
- Sits between the keypad pins and the digit storage / seven-segment multiplexing logic, replacing ad-hoc scanning with one owned FSM.

Parameters:
- SCAN_DIV, 24'd10000, clk cycles each column stays driven before rows are sampled; must be >= 3.
- DEBOUNCE_CYCLES, 24'd150000, consecutive stable cycles required to accept a press, and again to accept a release.
- REPEAT_CYCLES, 24'd3000000, auto-repeat period; used only when KEYPAD_REPEAT_EN is defined.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- row_n  input  4  raw keypad rows; active-low (pulled up); asynchronous to clk
- col_n  output  4  column drive; one-hot active-low; exactly one bit low at all times
- key_valid  output  1  one-cycle pulse when a debounced key is accepted
- key_code  output  4  hex value of last accepted key; holds between pulses
- key_held  output  1  high while an accepted key remains pressed

Behaviour:
- Reset (`reset`=0 at posedge clk): state SCAN, `col_n`=4'b1110 (column 0), `key_valid`=0, `key_code`=4'h0, `key_held`=0, all counters 0, synchronizer flops 4'b1111.
- Synchronization: `row_n` passes through a 2-flop synchronizer to give `rs`; row r is pressed when `rs[r]`=0.
- Timing: column dwell counter counts 0..SCAN_DIV-1. Rows are sampled only when the count equals SCAN_DIV-1, so 2-cycle sync latency plus settle is covered.
- States:
  - SCAN: at sample time, if no row is pressed, advance the column 0→1→2→3→0 (wrap) and clear the dwell counter. If any row is pressed, latch `lat_col` (current column) and `lat_row`, then go to DEB_PRESS with the column frozen. If multiple rows are low, the lowest index row wins.
  - DEB_PRESS: count cycles while `rs[lat_row]`=0.
    - Latched row goes high before DEBOUNCE_CYCLES: return to SCAN, advance to the next column, no output.
    - Count reaches DEBOUNCE_CYCLES: set `key_code`=MAP[lat_row][lat_col], pulse `key_valid` for 1 cycle, set `key_held`=1, go to HELD.
  - HELD: column frozen; other keys are ignored (single-key lockout). On `rs[lat_row]`=1, go to DEB_RELEASE.
  - DEB_RELEASE: count cycles while `rs[lat_row]`=1. Any low sample returns to HELD with the count cleared. Reaching DEBOUNCE_CYCLES clears `key_held`, advances the column, and goes to SCAN.
- Key map (row, col0..3):
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: E 0 F D
- Counters are 24-bit and saturate; they never wrap.
- `key_valid` is never asserted in two consecutive cycles.
- Reset mid-press: state returns to SCAN immediately. A key still held after reset is re-debounced and re-reported.

Optional Feature:
- KEYPAD_REPEAT_EN defined: in HELD, a repeat counter re-pulses `key_valid` (same `key_code`) every REPEAT_CYCLES cycles. The first repeat comes REPEAT_CYCLES after the initial pulse. The counter clears on leaving HELD and is not reset by a return from DEB_RELEASE bounce.
- Undefined: exactly one pulse per press; no repeat counter is synthesized.

Decomposition:
- Package `keypad_pkg`: state enum (SCAN, DEB_PRESS, HELD, DEB_RELEASE), 4x4 key-map constant, `col_onehot_n(idx)` function, lowest-row priority-encode function.
- One sub-module: `sync2`, a parameterizable-width 2-flop synchronizer instantiated on `row_n`.

Test Plan (SCAN_DIV=4, DEBOUNCE_CYCLES=8, REPEAT_CYCLES=32):
- Reset, no keys → `col_n` cycles 1110,1101,1011,0111,1110 every 4 clks; `key_valid` never asserts.
- Hold row1 low only while col2 driven, for 40 clks → single `key_valid` pulse, `key_code`=4'h6, `key_held`=1; release → `key_held` falls 8 clks after sync'd release, scan resumes at col3.
- Row0/col0 low for 5 clks then released (bounce) → no `key_valid`; scanning resumes.
- Press row3/col1 ('0'), toggle row3 high 3 clks mid-release, then settle → one press pulse only; `key_held` clears 8 stable clks after final release.
- Row2 and row0 low together at col3 → `key_code`=4'hA; a second key in col0 pressed while held → ignored.
- KEYPAD_REPEAT_EN, hold '5' for 120 clks after accept → pulses at accept, +32, +64, +96, all `key_code`=4'h5; without the macro → one pulse.
